q_div: RTL and testbench

Sequential signed fixed-point divider for the datapath arithmetic library. It divides two N-bit sign-magnitude Q-format operands, with Q fractional bits and bit N-1 as the sign. It uses radix-2 restoring division, one quotient bit per clock. It is used wherever a non-pipelined, low-area fixed-point divide is acceptable; throughput is one result per N-1+1 cycles.

---
 rtl/q_div.sv | 134 +++++++++++++
 tb/tb_q_div.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/q_div.sv
// Sequential sign-magnitude Q-format divider: radix-2 restoring division,
// one quotient bit per clock, result and flags registered together at the end.
//
// state | meaning
// IDLE  | result held (done=1), or post-reset with done=0
// LOAD  | start high: operands captured, unit held
// RUN   | one restoring iteration per cycle, N-1 in total
module q_div #(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   input  logic         start,
   output logic [N-1:0] quotient,
   output logic         done,
   output logic         overflow
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   rem_q, rem_d;
   logic [N-2:0]   b_q, b_d;
   logic [N-2:0]   abits_q, abits_d;
   logic [N-2:0]   acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sign_q, sign_d;
   logic           ovf_cap_q, ovf_cap_d;
   logic [N-1:0]   quotient_q, quotient_d;
   logic           done_q, done_d;
   logic           overflow_q, overflow_d;

   logic [N-2:0]   a_mag;
   logic [N-2:0]   a_prefix;
   logic [N:0]     r_wide;
   logic [N-1:0]   diff;
   logic           qbit;
   logic [N-2:0]   mag_final;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         b_q        <= '0;
         abits_q    <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         ovf_cap_q  <= 1'b0;
         quotient_q <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         b_q        <= b_d;
         abits_q    <= abits_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
         ovf_cap_q  <= ovf_cap_d;
         quotient_q <= quotient_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      b_d        = b_q;
      abits_d    = abits_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      ovf_cap_d  = ovf_cap_q;
      quotient_d = quotient_q;
      done_d     = done_q;
      overflow_d = overflow_q;

      a_mag    = dividend[N-2:0];
      a_prefix = a_mag >> (N-1-Q);

      // rem stays below the divisor, so R' fits N bits and the N-bit subtract is exact
      r_wide    = {rem_q, abits_q[N-2]};
      qbit      = (r_wide >= {2'b00, b_q});
      diff      = r_wide[N-1:0] - {1'b0, b_q};
      mag_final = {acc_q[N-3:0], qbit};

      if (start) begin
         state_d   = LOAD;
         rem_d     = {1'b0, a_prefix};
         b_d       = divisor[N-2:0];
         abits_d   = a_mag << Q;
         sign_d    = dividend[N-1] ^ divisor[N-1];
         ovf_cap_d = (a_prefix >= divisor[N-2:0]);
         acc_d     = '0;
         cnt_d     = '0;
         done_d    = 1'b0;
      end else begin
         case (state_q)
            LOAD, RUN: begin
               rem_d   = qbit ? diff : r_wide[N-1:0];
               abits_d = abits_q << 1;
               acc_d   = mag_final;
               cnt_d   = cnt_q + CW'(1);
               state_d = RUN;
               if (cnt_q == CW'(N-2)) begin
                  state_d    = IDLE;
                  done_d     = 1'b1;
                  overflow_d = ovf_cap_q;
                  if (ovf_cap_q)
                     quotient_d = {sign_q, {(N-1){1'b1}}};
                  else if (mag_final == '0)
                     quotient_d = '0;
                  else
                     quotient_d = {sign_q, mag_final};
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient = quotient_q;
   assign done     = done_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_q_div.sv
// Self-checking bench for q_div: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal results and latencies.
module tb_q_div;

   localparam int Q = 15;
   localparam int N = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  dividend;
   logic [N-1:0]  divisor;
   logic          start;
   logic [N-1:0]  quotient;
   logic          done;
   logic          overflow;

   int checks   = 0;
   int failures = 0;

   q_div #(.Q(Q), .N(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .dividend (dividend),
      .divisor  (divisor),
      .start    (start),
      .quotient (quotient),
      .done     (done),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: {overflow, quotient} from plain integer arithmetic
   function automatic logic [N:0] model(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
      longint unsigned a, b, m;
      logic s;
      a = longint'(dvd[N-2:0]);
      b = longint'(dvs[N-2:0]);
      s = dvd[N-1] ^ dvs[N-1];
      if ((a >> (N-1-Q)) >= b) return {1'b1, s, {(N-1){1'b1}}};
      m = (a << Q) / b;
      if (m == 0) return '0;
      return {1'b0, s, m[N-2:0]};
   endfunction

   logic [N-1:0] exp_q = '0;
   logic         exp_done = 1'b0;
   logic         exp_ovf = 1'b0;
   logic         busy = 1'b0;
   int           ecnt = 0;
   logic [N-1:0] cap_dvd, cap_dvs;

   always @(posedge clk or posedge reset) begin
      logic [N:0] r;
      if (reset) begin
         exp_q = '0; exp_done = 1'b0; exp_ovf = 1'b0; busy = 1'b0;
      end else if (start) begin
         cap_dvd = dividend; cap_dvs = divisor;
         busy = 1'b1; ecnt = 0; exp_done = 1'b0;
      end else if (busy) begin
         ecnt++;
         if (ecnt == N-1) begin
            r = model(cap_dvd, cap_dvs);
            exp_ovf = r[N]; exp_q = r[N-1:0]; exp_done = 1'b1; busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_done", {31'b0, done}, {31'b0, exp_done});
      chk("cyc_quotient", quotient, exp_q);
      if (exp_done) chk("cyc_overflow", {31'b0, overflow}, {31'b0, exp_ovf});
   end

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
      end
   endtask

   task automatic do_div(input string name, input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                         input int nstart, input logic [N-1:0] xq, input logic xovf);
      int lat;
      @(posedge clk); #2;
      dividend = dvd; divisor = dvs; start = 1'b1;
      repeat (nstart) @(posedge clk);
      #2;
      start = 1'b0;
      dividend = ~dvd; divisor = ~dvs;
      wait_done(lat);
      chk({name, "_latency"}, N'(lat), N'(31));
      chk({name, "_q"}, quotient, xq);
      chk({name, "_ovf"}, {31'b0, overflow}, {31'b0, xovf});
   endtask

   initial begin
      int lat;
      int seen;
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;

      chk("model_basic", model(32'h80104000, 32'h00012000), 33'h0_800738E3);
      chk("model_trunc", model(32'h00008000, 32'h00018000), 33'h0_00002AAA);
      chk("model_ovf",   model(32'h75300000, 32'h00004000), 33'h1_7FFFFFFF);
      chk("model_dbz",   model(32'h80008000, 32'h00000000), 33'h1_FFFFFFFF);
      chk("model_negz",  model(32'h80000001, 32'h00020000), 33'h0_00000000);

      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst_q", quotient, '0);
      chk("rst_done", {31'b0, done}, '0);
      chk("rst_ovf", {31'b0, overflow}, '0);

      do_div("basic",   32'h80104000, 32'h00012000, 10, 32'h800738E3, 1'b0);
      do_div("trunc",   32'h00008000, 32'h00018000, 1,  32'h00002AAA, 1'b0);
      do_div("trunc_nn",32'h80008000, 32'h80018000, 2,  32'h00002AAA, 1'b0);
      do_div("ovf",     32'h75300000, 32'h00004000, 1,  32'h7FFFFFFF, 1'b1);
      do_div("dbz",     32'h80008000, 32'h00000000, 3,  32'hFFFFFFFF, 1'b1);
      do_div("negz",    32'h80000001, 32'h00020000, 1,  32'h00000000, 1'b0);
      do_div("plain",   32'h00030000, 32'h80008000, 1,  32'h80030000, 1'b0);

      // reset mid-run: outputs clear at once and no result follows
      @(posedge clk); #2;
      dividend = 32'h80104000; divisor = 32'h00012000; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_q", quotient, '0);
      chk("midrst_done", {31'b0, done}, '0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (done) seen++; end
      chk("midrst_no_done", N'(seen), '0);

      // abort: restart mid-run with new operands
      @(posedge clk); #2;
      dividend = 32'h00008000; divisor = 32'h00018000; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      seen = 0;
      repeat (10) begin @(posedge clk); #1; if (done) seen++; end
      chk("abort_no_early_done", N'(seen), '0);
      do_div("abort_new", 32'h80104000, 32'h00012000, 2, 32'h800738E3, 1'b0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
